// File: rtl/led_matrix_spi_rx.sv
// Receive-side SPI decoder for the 8x8 LED matrix link: oversamples sclk/mosi/n_cs,
// deserialises MSB-first bytes and turns them into pixel writes or frame-index resets.
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | not selected; sclk edges ignored, waiting for n_cs fall
// ST_RX   | selected; shifting bits, disposing the pending byte at n_cs rise
module led_matrix_spi_rx #(
    parameter int         PIXEL_COUNT           = 64,
    parameter int         SYNC_STAGES           = 2,
    parameter logic [7:0] CMD_RESET_FRAME_INDEX = 8'h26
) (
    input  logic       i_clock,
    input  logic       i_reset,
    input  logic       i_sclk,
    input  logic       i_mosi,
    input  logic       i_n_cs,
    output logic       o_rx_valid,
    output logic [7:0] o_rx_byte,
    output logic       o_pix_we,
    output logic [5:0] o_pix_addr,
    output logic [5:0] o_pix_data,
    output logic       o_cmd_reset,
    output logic       o_frame_done,
    output logic       o_framing_err
);

    typedef enum logic {ST_IDLE = 1'b0, ST_RX = 1'b1} state_t;

    localparam int         FLUSH_W  = $clog2(SYNC_STAGES + 2);
    localparam logic [5:0] LAST_IDX = 6'(PIXEL_COUNT - 1);

    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic                   r_sclk_prev;
    logic                   r_cs_prev;
    logic [FLUSH_W-1:0]     r_flush_cnt;

    state_t     r_state;
    state_t     w_state_next;
    logic [2:0] r_bit_cnt;
    logic [1:0] r_byte_cnt;
    logic [6:0] r_shift;
    logic [7:0] r_pending;
    logic [5:0] r_frame_idx;

    logic       w_sclk;
    logic       w_mosi;
    logic       w_cs;
    logic       w_edges_ok;
    logic       w_sclk_rise;
    logic       w_cs_fall;
    logic       w_cs_rise;

    logic       w_arm;
    logic       w_close;
    logic       w_shift;
    logic       w_byte_done;
    logic       w_pend_valid;
    logic       w_is_cmd;
    logic       w_write;
    logic       w_framing;
    logic [7:0] w_new_byte;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_sclk_sync <= '0;
            r_mosi_sync <= '0;
            r_cs_sync   <= '1;
            r_sclk_prev <= 1'b0;
            r_cs_prev   <= 1'b1;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], i_sclk};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], i_mosi};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], i_n_cs};
            r_sclk_prev <= w_sclk;
            r_cs_prev   <= w_cs;
        end
    end

    // Edges are masked until the synchroniser has refilled from the pins after reset,
    // so a chip select held low across reset does not look like a fresh n_cs fall.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_flush_cnt <= FLUSH_W'(SYNC_STAGES + 1);
        end else if (r_flush_cnt != '0) begin
            r_flush_cnt <= r_flush_cnt - 1'b1;
        end
    end

    assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
    assign w_mosi      = r_mosi_sync[SYNC_STAGES-1];
    assign w_cs        = r_cs_sync[SYNC_STAGES-1];
    assign w_edges_ok  = (r_flush_cnt == '0);
    assign w_sclk_rise = w_edges_ok & w_sclk & ~r_sclk_prev;
    assign w_cs_fall   = w_edges_ok & ~w_cs & r_cs_prev;
    assign w_cs_rise   = w_edges_ok & w_cs & ~r_cs_prev;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_cs_fall) w_state_next = ST_RX;
            ST_RX:   if (w_cs_rise) w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // n_cs rise beats a coincident sclk rise; the pending byte is only valid once one byte landed.
    always_comb begin
        w_arm        = (r_state == ST_IDLE) & w_cs_fall;
        w_close      = (r_state == ST_RX) & w_cs_rise;
        w_shift      = (r_state == ST_RX) & w_sclk_rise & ~w_cs_rise;
        w_byte_done  = w_shift & (r_bit_cnt == 3'd7);
        w_new_byte   = {r_shift, w_mosi};
        w_pend_valid = (r_byte_cnt != 2'd0);
        w_is_cmd     = w_close & (r_byte_cnt == 2'd1) & (r_pending == CMD_RESET_FRAME_INDEX);
        w_write      = (w_byte_done | w_close) & w_pend_valid & ~w_is_cmd;
        w_framing    = w_close & (r_bit_cnt != 3'd0);
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_bit_cnt     <= 3'd0;
            r_byte_cnt    <= 2'd0;
            r_shift       <= 7'd0;
            r_pending     <= 8'd0;
            r_frame_idx   <= 6'd0;
            o_rx_valid    <= 1'b0;
            o_rx_byte     <= 8'd0;
            o_pix_we      <= 1'b0;
            o_pix_addr    <= 6'd0;
            o_pix_data    <= 6'd0;
            o_cmd_reset   <= 1'b0;
            o_frame_done  <= 1'b0;
            o_framing_err <= 1'b0;
        end else begin
            o_rx_valid    <= 1'b0;
            o_pix_we      <= 1'b0;
            o_cmd_reset   <= 1'b0;
            o_frame_done  <= 1'b0;
            o_framing_err <= w_framing;

            if (w_arm) begin
                r_bit_cnt  <= 3'd0;
                r_byte_cnt <= 2'd0;
                r_shift    <= 7'd0;
                r_pending  <= 8'd0;
            end

            if (w_shift) begin
                r_shift   <= w_new_byte[6:0];
                r_bit_cnt <= r_bit_cnt + 3'd1;
            end

            if (w_byte_done) begin
                o_rx_valid <= 1'b1;
                o_rx_byte  <= w_new_byte;
                r_pending  <= w_new_byte;
                r_byte_cnt <= (r_byte_cnt == 2'd2) ? 2'd2 : r_byte_cnt + 2'd1;
            end

            if (w_close) begin
                r_bit_cnt  <= 3'd0;
                r_byte_cnt <= 2'd0;
            end

            if (w_write) begin
                o_pix_we     <= 1'b1;
                o_pix_addr   <= r_frame_idx;
                o_pix_data   <= r_pending[5:0];
                o_frame_done <= (r_frame_idx == LAST_IDX);
                r_frame_idx  <= (r_frame_idx == LAST_IDX) ? 6'd0 : r_frame_idx + 6'd1;
            end

            if (w_is_cmd) begin
                o_cmd_reset <= 1'b1;
                r_frame_idx <= 6'd0;
            end
        end
    end

endmodule

// File: tb/tb_led_matrix_spi_rx.sv
// Scoreboard bench for led_matrix_spi_rx: stimulus pushes expected events from a
// transaction-level model, a negedge monitor pops and compares as the DUT pulses.
module tb_led_matrix_spi_rx;

    typedef struct {
        logic [5:0] addr;
        logic [5:0] data;
        logic       fd;
        logic       at_close;
    } pix_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sclk = 1'b0;
    logic       mosi = 1'b0;
    logic       n_cs = 1'b1;
    logic       rx_valid;
    logic [7:0] rx_byte;
    logic       pix_we;
    logic [5:0] pix_addr;
    logic [5:0] pix_data;
    logic       cmd_reset;
    logic       frame_done;
    logic       framing_err;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] exp_rx[$];
    pix_t       exp_pix[$];
    int         exp_cmd = 0;
    int         exp_ferr = 0;
    int         m_idx = 0;
    logic [7:0] tx_q[$];
    logic [7:0] mon_b;
    pix_t       mon_e;

    led_matrix_spi_rx dut (
        .i_clock      (clk),
        .i_reset      (rst),
        .i_sclk       (sclk),
        .i_mosi       (mosi),
        .i_n_cs       (n_cs),
        .o_rx_valid   (rx_valid),
        .o_rx_byte    (rx_byte),
        .o_pix_we     (pix_we),
        .o_pix_addr   (pix_addr),
        .o_pix_data   (pix_data),
        .o_cmd_reset  (cmd_reset),
        .o_frame_done (frame_done),
        .o_framing_err(framing_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic unexpected(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: got pulse expected none", name);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (pix_we || cmd_reset)
                check("pix_we_and_cmd_reset_together", {31'd0, pix_we & cmd_reset}, 32'd0);
            if (rx_valid) begin
                if (exp_rx.size() == 0) unexpected("rx_valid");
                else begin
                    mon_b = exp_rx.pop_front();
                    check("rx_byte", {24'd0, rx_byte}, {24'd0, mon_b});
                end
            end
            if (pix_we) begin
                if (exp_pix.size() == 0) unexpected("pix_we");
                else begin
                    mon_e = exp_pix.pop_front();
                    check("pix_addr", {26'd0, pix_addr}, {26'd0, mon_e.addr});
                    check("pix_data", {26'd0, pix_data}, {26'd0, mon_e.data});
                    check("frame_done", {31'd0, frame_done}, {31'd0, mon_e.fd});
                    check("pix_we_with_rx_valid", {31'd0, rx_valid}, {31'd0, ~mon_e.at_close});
                end
            end else if (frame_done) begin
                unexpected("frame_done_without_pix_we");
            end
            if (cmd_reset) begin
                if (exp_cmd == 0) unexpected("cmd_reset");
                else exp_cmd--;
            end
            if (framing_err) begin
                if (exp_ferr == 0) unexpected("framing_err");
                else exp_ferr--;
            end
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        mosi = b;
        wait_clk(4);
        sclk = 1'b1;
        wait_clk(4);
        sclk = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
    endtask

    // Transaction-level reference: a lone command byte resets the index, everything else is pixels.
    task automatic run_tx(input int partial);
        int n;
        n = tx_q.size();
        foreach (tx_q[k]) exp_rx.push_back(tx_q[k]);
        if (n == 1 && tx_q[0] == 8'h26) begin
            exp_cmd++;
            m_idx = 0;
        end else begin
            for (int k = 0; k < n; k++) begin
                exp_pix.push_back('{addr: 6'(m_idx), data: tx_q[k][5:0],
                                    fd: (m_idx == 63), at_close: (k == n - 1)});
                m_idx = (m_idx + 1) % 64;
            end
        end
        if (partial != 0) exp_ferr++;
        wait_clk(2);
        n_cs = 1'b0;
        wait_clk(4);
        foreach (tx_q[k]) send_byte(tx_q[k]);
        for (int i = 0; i < partial; i++) send_bit(1'($urandom_range(0, 1)));
        wait_clk(4);
        n_cs = 1'b1;
        wait_clk(10);
        tx_q.delete();
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_rx_byte"}, {24'd0, rx_byte}, 32'd0);
        check({tag, "_pix_addr"}, {26'd0, pix_addr}, 32'd0);
        check({tag, "_pix_data"}, {26'd0, pix_data}, 32'd0);
        check({tag, "_pulses"}, {27'd0, rx_valid, pix_we, cmd_reset, frame_done, framing_err}, 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int len;
        int part;
        wait_clk(5);
        check_idle_outputs("reset");
        rst = 1'b0;
        wait_clk(5);

        tx_q.push_back(8'h26);
        run_tx(0);

        for (int k = 0; k < 64; k++) tx_q.push_back(8'(k));
        run_tx(0);

        tx_q.push_back(8'h15);
        run_tx(0);

        tx_q.push_back(8'h26);
        run_tx(0);
        tx_q.push_back(8'h26);
        tx_q.push_back(8'h01);
        run_tx(0);

        run_tx(5);
        tx_q.push_back(8'hA7);
        run_tx(0);

        // Reset mid-byte with chip select held low; the following bits must be ignored.
        n_cs = 1'b0;
        wait_clk(4);
        for (int i = 0; i < 3; i++) send_bit(1'b1);
        rst = 1'b1;
        wait_clk(3);
        check_idle_outputs("midreset");
        rst = 1'b0;
        m_idx = 0;
        send_byte(8'h33);
        send_byte(8'h26);
        wait_clk(4);
        n_cs = 1'b1;
        wait_clk(10);
        check_idle_outputs("after_reset");
        tx_q.push_back(8'h15);
        run_tx(0);

        for (int t = 0; t < 25; t++) begin
            len = $urandom_range(0, 4);
            for (int k = 0; k < len; k++)
                tx_q.push_back(($urandom_range(0, 2) == 0) ? 8'h26 : 8'($urandom));
            part = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
            if (len == 0 && part == 0) part = 3;
            run_tx(part);
        end

        wait_clk(20);
        check("leftover_rx", exp_rx.size(), 32'd0);
        check("leftover_pix", exp_pix.size(), 32'd0);
        check("leftover_cmd", exp_cmd, 32'd0);
        check("leftover_ferr", exp_ferr, 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
